dic_ctrl_param: RTL
===================

# dic_ctrl_param

Parametrised command controller for the digital clock. It consumes UART characters and drives run, alarm and load control for an N-digit clock datapath. It supports a per-digit 0–5 / 0–9 range mask, early commit on carriage return, abort on ESC, and a registered digit-value bus. It sits between the UART receiver and the clock/alarm counters, and replaces the fixed four-digit control.

## Interface
- NDIG, 4: number of display/load digits, 2–8; index 0 is the least significant digit.
- TENS_MASK, 4'b1010: NDIG-bit mask; a bit set limits that digit to 0–5, a bit clear allows 0–9.
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rx_data_rdy  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  ASCII character
- dicRun  out  1  clock counters advance
- alarm_ena  out  1  alarm compare enabled
- ld_time  out  1  high for the whole time-load session
- ld_alarm  out  1  high for the whole alarm-load session
- dicSelectLEDdisp  out  1  LED display select, toggled by 'N'
- dicDsp  out  NDIG  per-digit display enable
- dicLd  out  NDIG  one-hot one-cycle load strobe
- ld_digit  out  4  BCD value accompanying dicLd

## Operation
- FSM states are RUN, STOP, LOAD_T and LOAD_A. The digit index register dig_idx holds values NDIG-1 down to 0.
- Character decode:
  - 'L' (0x4C) requests a time load.
  - 'A' (0x41) requests an alarm load.
  - '@' (0x40) toggles alarm_ena.
  - 'S' (0x53) toggles run/stop.
  - 'N' (0x4E) toggles dicSelectLEDdisp.
  - CR (0x0D) commits a load.
  - ESC (0x1B) aborts a load.
  - '0'–'9' are digits.
- RUN: dicRun=1. 'S' goes to STOP. 'L' goes to LOAD_T. 'A' goes to LOAD_A. Every other character is ignored.
- STOP: dicRun=0. 'S' goes to RUN. 'L' and 'A' behave as in RUN.
- On entering LOAD_T or LOAD_A: dicRun=0 and dig_idx=NDIG-1.
- In LOAD_T or LOAD_A, a digit is accepted when it is in range for dig_idx per TENS_MASK:
  - dicLd[dig_idx] pulses for one cycle and ld_digit carries the digit value.
  - dig_idx decrements.
  - Accepting digit 0 returns the FSM to RUN.
- In LOAD_T or LOAD_A, an out-of-range digit is ignored and dig_idx does not advance.
- In LOAD_T or LOAD_A:
  - CR returns to RUN; digits already loaded are kept and digits not yet entered are unchanged.
  - ESC returns to the state held before the load (RUN or STOP), with no further strobes.
  - 'L', 'A', 'S' and '@' are ignored.
  - 'N' still toggles dicSelectLEDdisp.
- dicDsp is all ones outside load. During load it is one-hot at dig_idx, so only the digit awaiting entry is shown.
- Reset values:
  - state=RUN, dicRun=1.
  - alarm_ena=0, ld_time=0, ld_alarm=0, dicSelectLEDdisp=0.
  - dicDsp all ones, dicLd=0, ld_digit=0, dig_idx=NDIG-1.

## Timing
- All outputs are registered. Latency is 1 cycle from the rx_data_rdy strobe to the state change, dicLd pulse or toggle.
- rx_data_rdy must be low for at least one cycle between characters. Each high cycle counts as one character.
- ld_time and ld_alarm rise in the cycle after 'L' or 'A'. They fall in the same cycle as the final dicLd pulse or the CR/ESC response.
- ld_digit is held from the dicLd pulse until the next accepted digit.
- If rst and rx_data_rdy are high in the same cycle, rst wins and the character is dropped.
- Reset during a load aborts it with no dicLd pulse.
- dig_idx never wraps. Leaving load from index 0 always reloads NDIG-1.

## Configuration
- DIC_ALARM_EN defined: 'A' and '@' behave as described above.
- DIC_ALARM_EN undefined:
  - LOAD_A is not synthesised.
  - alarm_ena and ld_alarm are tied to 0.
  - 'A' and '@' are ignored in every state.

## Structure
- Package dic_pkg holds:
  - the state enum (RUN, STOP, LOAD_T, LOAD_A);
  - the ASCII constants (L, A, @, S, N, CR, ESC, '0', '9');
  - the 4-bit BCD digit type.
- One sub-module, dic_key_decode, holds the registered-input-free combinational decode. Its outputs are det_num, det_num0to5, det_cr, det_esc, det_L, det_A, det_atSign, det_S, det_N and digit[3:0]. The parent instantiates it once.

## Test plan
- Reset, then idle 5 cycles -> dicRun=1, alarm_ena=0, dicDsp=4'b1111, dicLd=0.
- Send "L1234" -> ld_time high, dicLd pulses 1000/0100/0010/0001 with ld_digit 1,2,3,4, then RUN with dicRun=1.
- Send "L7", then "L6" -> the '7' and the '6' are both rejected at index 3 (range 0–5) with no strobe, and dicDsp stays 4'b1000.
- Send "S", then "L12", then ESC -> two strobes are issued, then the FSM returns to STOP with dicRun=0 and ld_time=0.
- Send "A05" then CR, with DIC_ALARM_EN -> ld_alarm pulses dicLd[3], dicLd[2] with ld_digit 0 and 5, and CR ends the load. Without the macro, no ld_alarm and no strobes.
- Assert rst mid "L12" with NDIG=6, TENS_MASK=6'b101010 -> no further strobes, reset values restored, and a following "L959" is rejected at index 5 with no strobe.

Source files
------------

// File: rtl/dic_pkg.sv
// Shared types and ASCII constants for the parametrised digital-clock command controller.
package dic_pkg;

  typedef enum logic [1:0] {RUN, STOP, LOAD_T, LOAD_A} dic_state_e;

  typedef logic [3:0] bcd_t;

  localparam logic [7:0] ASC_L   = 8'h4C;
  localparam logic [7:0] ASC_A   = 8'h41;
  localparam logic [7:0] ASC_AT  = 8'h40;
  localparam logic [7:0] ASC_S   = 8'h53;
  localparam logic [7:0] ASC_N   = 8'h4E;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_ESC = 8'h1B;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;

endpackage

// File: rtl/dic_key_decode.sv
// Combinational decode of one received ASCII character into command/digit flags.
module dic_key_decode
  import dic_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       det_num,
  output logic       det_num0to5,
  output logic       det_cr,
  output logic       det_esc,
  output logic       det_L,
  output logic       det_A,
  output logic       det_atSign,
  output logic       det_S,
  output logic       det_N,
  output bcd_t       digit
);

  assign det_num     = (rx_data >= ASC_0) && (rx_data <= ASC_9);
  assign det_num0to5 = det_num && (rx_data[3:0] <= 4'd5);
  assign det_cr      = (rx_data == ASC_CR);
  assign det_esc     = (rx_data == ASC_ESC);
  assign det_L       = (rx_data == ASC_L);
  assign det_A       = (rx_data == ASC_A);
  assign det_atSign  = (rx_data == ASC_AT);
  assign det_S       = (rx_data == ASC_S);
  assign det_N       = (rx_data == ASC_N);
  assign digit       = rx_data[3:0];

endmodule

// File: rtl/dic_ctrl_param.sv
// N-digit clock command controller: run/stop, time/alarm digit load, display select.
// Alarm commands ('A', '@') and the LOAD_A session exist only when DIC_ALARM_EN is defined.
module dic_ctrl_param
  import dic_pkg::*;
#(
  parameter int              NDIG      = 4,
  parameter logic [NDIG-1:0] TENS_MASK = 4'b1010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_data_rdy,
  input  logic [7:0]      rx_data,
  output logic            dicRun,
  output logic            alarm_ena,
  output logic            ld_time,
  output logic            ld_alarm,
  output logic            dicSelectLEDdisp,
  output logic [NDIG-1:0] dicDsp,
  output logic [NDIG-1:0] dicLd,
  output logic [3:0]      ld_digit
);

  localparam int             IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0]  LAST = IW'(NDIG - 1);

  logic det_num, det_num0to5, det_cr, det_esc, det_L, det_A, det_atSign, det_S, det_N;
  bcd_t digit;

  dic_key_decode u_dec (
    .rx_data     (rx_data),
    .det_num     (det_num),
    .det_num0to5 (det_num0to5),
    .det_cr      (det_cr),
    .det_esc     (det_esc),
    .det_L       (det_L),
    .det_A       (det_A),
    .det_atSign  (det_atSign),
    .det_S       (det_S),
    .det_N       (det_N),
    .digit       (digit)
  );

  dic_state_e      state_q, state_d, prev_q, prev_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            sel_q, sel_d, run_q, run_d, ldt_q, ldt_d;
  logic [NDIG-1:0] dsp_q, dsp_d, ld_q, ld_d;
  bcd_t            dig_q, dig_d;
  logic            in_range, loading_d;
`ifdef DIC_ALARM_EN
  logic            alarm_q, alarm_d, lda_q, lda_d;
`else
  logic            unused_alarm;
  assign unused_alarm = det_A ^ det_atSign;
`endif

  assign in_range = TENS_MASK[idx_q] ? det_num0to5 : det_num;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    ld_d    = '0;
    dig_d   = dig_q;
`ifdef DIC_ALARM_EN
    alarm_d = alarm_q;
`endif
    if (rx_data_rdy) begin
      if (det_N) sel_d = ~sel_q;
      case (state_q)
        RUN, STOP: begin
          if (det_S) state_d = (state_q == RUN) ? STOP : RUN;
          else if (det_L) begin
            state_d = LOAD_T;
            prev_d  = state_q;
            idx_d   = LAST;
          end
`ifdef DIC_ALARM_EN
          else if (det_A) begin
            state_d = LOAD_A;
            prev_d  = state_q;
            idx_d   = LAST;
          end
          else if (det_atSign) alarm_d = ~alarm_q;
`endif
        end
        default: begin
          // ESC restores the pre-load run/stop state; CR always resumes running
          if (det_esc) begin
            state_d = prev_q;
            idx_d   = LAST;
          end else if (det_cr) begin
            state_d = RUN;
            idx_d   = LAST;
          end else if (in_range) begin
            ld_d  = NDIG'(1) << idx_q;
            dig_d = digit;
            if (idx_q == '0) begin
              state_d = RUN;
              idx_d   = LAST;
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end
        end
      endcase
    end
    loading_d = (state_d == LOAD_T) || (state_d == LOAD_A);
    run_d     = (state_d == RUN);
    ldt_d     = (state_d == LOAD_T);
    dsp_d     = loading_d ? (NDIG'(1) << idx_d) : '1;
`ifdef DIC_ALARM_EN
    lda_d     = (state_d == LOAD_A);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      prev_q  <= RUN;
      idx_q   <= LAST;
      sel_q   <= 1'b0;
      run_q   <= 1'b1;
      ldt_q   <= 1'b0;
      dsp_q   <= '1;
      ld_q    <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      run_q   <= run_d;
      ldt_q   <= ldt_d;
      dsp_q   <= dsp_d;
      ld_q    <= ld_d;
      dig_q   <= dig_d;
    end
  end

`ifdef DIC_ALARM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_q <= 1'b0;
      lda_q   <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
      lda_q   <= lda_d;
    end
  end
  assign alarm_ena = alarm_q;
  assign ld_alarm  = lda_q;
`else
  assign alarm_ena = 1'b0;
  assign ld_alarm  = 1'b0;
`endif

  assign dicRun           = run_q;
  assign ld_time          = ldt_q;
  assign dicSelectLEDdisp = sel_q;
  assign dicDsp           = dsp_q;
  assign dicLd            = ld_q;
  assign ld_digit         = dig_q;

endmodule
